storage_port_arbiter: RTL and testbench

- Shares one single-port 32-bit storage SRAM bank between two requesters: the management core (read/write) and the housekeeping SPI read-only path.
- Sits between mgmt_core and storage, replacing the dedicated housekeeping read port.
- Sequences each access through the RAM's one-cycle read latency, registers all returned data, and acknowledges requesters with a one-cycle pulse.
- Uses round-robin arbitration when both requesters are pending.

---
 rtl/storage_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_storage_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/storage_port_arbiter.sv
// Two-requester arbiter sharing one single-port storage SRAM between the management
// core (read/write) and the housekeeping SPI read path. All outputs are registered.
module storage_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MGMT_FIRST = 1
) (
  input  logic                      core_clk,
  input  logic                      core_rstn,
  // management core port
  input  logic                      mgmt_req,
  input  logic                      mgmt_we,
  input  logic [DATA_WIDTH/8-1:0]   mgmt_sel,
  input  logic [ADDR_WIDTH-1:0]     mgmt_addr,
  input  logic [DATA_WIDTH-1:0]     mgmt_wdata,
  output logic                      mgmt_ack,
  output logic [DATA_WIDTH-1:0]     mgmt_rdata,
  // housekeeping read port
  input  logic                      hk_req,
  input  logic [ADDR_WIDTH-1:0]     hk_addr,
  output logic                      hk_ack,
  output logic [DATA_WIDTH-1:0]     hk_rdata,
  // SRAM port
  output logic                      ram_ena,
  output logic                      ram_wen,
  output logic [DATA_WIDTH/8-1:0]   ram_wen_mask,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic [DATA_WIDTH-1:0]     ram_rdata,
  output logic                      busy
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    owner_hk_q, owner_hk_d;
  logic                    we_q, we_d;
  logic                    last_hk_q, last_hk_d;
  logic                    grant_hk;

  logic                    ram_ena_d, ram_wen_d;
  logic [SEL_WIDTH-1:0]    ram_wen_mask_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_d;
  logic                    mgmt_ack_d, hk_ack_d;
  logic [DATA_WIDTH-1:0]   mgmt_rdata_d, hk_rdata_d;

  // Round robin: with both pending, the requester not served last wins.
  assign grant_hk = hk_req && (!mgmt_req || !last_hk_q);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d        = state_q;
    owner_hk_d     = owner_hk_q;
    we_d           = we_q;
    last_hk_d      = last_hk_q;
    ram_ena_d      = 1'b0;
    ram_wen_d      = 1'b0;
    ram_wen_mask_d = '0;
    ram_addr_d     = ram_addr;
    ram_wdata_d    = ram_wdata;
    mgmt_ack_d     = 1'b0;
    hk_ack_d       = 1'b0;
    mgmt_rdata_d   = mgmt_rdata;
    hk_rdata_d     = hk_rdata;

    unique case (state_q)
      IDLE: begin
        if (mgmt_req || hk_req) begin
          state_d    = ACCESS;
          owner_hk_d = grant_hk;
          last_hk_d  = grant_hk;
          ram_ena_d  = 1'b1;
          if (grant_hk) begin
            we_d       = 1'b0;
            ram_addr_d = hk_addr;
          end else begin
            we_d           = mgmt_we;
            ram_wen_d      = mgmt_we;
            ram_wen_mask_d = mgmt_we ? mgmt_sel : '0;
            ram_addr_d     = mgmt_addr;
            ram_wdata_d    = mgmt_wdata;
          end
        end
      end

      ACCESS: state_d = WAIT;

      WAIT: begin
        // RAM data is valid now, one cycle after the enable cycle.
        if (!we_q) begin
          if (owner_hk_q) hk_rdata_d   = ram_rdata;
          else            mgmt_rdata_d = ram_rdata;
        end
        if (owner_hk_q) hk_ack_d   = 1'b1;
        else            mgmt_ack_d = 1'b1;
        state_d = ACK;
      end

      ACK: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q      <= IDLE;
      owner_hk_q   <= 1'b0;
      we_q         <= 1'b0;
      last_hk_q    <= (MGMT_FIRST != 0);
      ram_ena      <= 1'b0;
      ram_wen      <= 1'b0;
      ram_wen_mask <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      mgmt_ack     <= 1'b0;
      hk_ack       <= 1'b0;
      // NOTE: the returned-data registers are plain flops, not a memory array,
      // so they are cleared on reset like any other output.
      mgmt_rdata   <= '0;
      hk_rdata     <= '0;
    end else begin
      state_q      <= state_d;
      owner_hk_q   <= owner_hk_d;
      we_q         <= we_d;
      last_hk_q    <= last_hk_d;
      ram_ena      <= ram_ena_d;
      ram_wen      <= ram_wen_d;
      ram_wen_mask <= ram_wen_mask_d;
      ram_addr     <= ram_addr_d;
      ram_wdata    <= ram_wdata_d;
      mgmt_ack     <= mgmt_ack_d;
      hk_ack       <= hk_ack_d;
      mgmt_rdata   <= mgmt_rdata_d;
      hk_rdata     <= hk_rdata_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_storage_port_arbiter.sv
// Self-checking bench for storage_port_arbiter: behavioural SRAM, vector table,
// scoreboard of expected acknowledgements and hand-written corner sequences.
module tb_storage_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          core_clk = 1'b0;
  logic          core_rstn = 1'b0;
  logic          mgmt_req = 1'b0, mgmt_we = 1'b0;
  logic [SW-1:0] mgmt_sel = '0;
  logic [AW-1:0] mgmt_addr = '0;
  logic [DW-1:0] mgmt_wdata = '0;
  logic          mgmt_ack;
  logic [DW-1:0] mgmt_rdata;
  logic          hk_req = 1'b0;
  logic [AW-1:0] hk_addr = '0;
  logic          hk_ack;
  logic [DW-1:0] hk_rdata;
  logic          ram_ena, ram_wen;
  logic [SW-1:0] ram_wen_mask;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          busy;

  always #5 core_clk = ~core_clk;

  storage_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MGMT_FIRST(1)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .mgmt_req(mgmt_req), .mgmt_we(mgmt_we), .mgmt_sel(mgmt_sel),
    .mgmt_addr(mgmt_addr), .mgmt_wdata(mgmt_wdata),
    .mgmt_ack(mgmt_ack), .mgmt_rdata(mgmt_rdata),
    .hk_req(hk_req), .hk_addr(hk_addr), .hk_ack(hk_ack), .hk_rdata(hk_rdata),
    .ram_ena(ram_ena), .ram_wen(ram_wen), .ram_wen_mask(ram_wen_mask),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  // Single-port SRAM with one-cycle read latency and per-byte write enables.
  logic [DW-1:0] mem [2**AW];
  always @(posedge core_clk) begin
    if (ram_ena) begin
      if (ram_wen) begin
        for (int b = 0; b < SW; b++)
          if (ram_wen_mask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  typedef struct {
    bit          hk;
    logic [DW-1:0] rdata;
  } sb_t;

  typedef struct {
    bit            hk;
    bit            we;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  sb_t           sb_q[$];
  vec_t          vecs[11];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_mgmt_rd = '0;
  logic [DW-1:0] exp_hk_rd   = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycle();
    @(posedge core_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ram_ena"}, 32'(ram_ena), 0);
    check({tag, " ram_wen"}, 32'(ram_wen), 0);
    check({tag, " ram_mask"}, 32'(ram_wen_mask), 0);
    check({tag, " ram_addr"}, 32'(ram_addr), 0);
    check({tag, " ram_wdata"}, ram_wdata, 0);
    check({tag, " acks"}, 32'({mgmt_ack, hk_ack}), 0);
    check({tag, " mgmt_rdata"}, mgmt_rdata, 0);
    check({tag, " hk_rdata"}, hk_rdata, 0);
    check({tag, " busy"}, 32'(busy), 0);
  endtask

  // Called in an ACK cycle: pops the oldest expectation and compares it.
  task automatic pop_compare();
    sb_t e;
    if (sb_q.size() == 0) begin
      check("sb_unexpected_ack", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("sb_owner", 32'(hk_ack), 32'(e.hk));
      if (e.hk) begin
        check("sb_hk_rdata", hk_rdata, e.rdata);
        check("sb_mgmt_rdata_kept", mgmt_rdata, exp_mgmt_rd);
        exp_hk_rd = e.rdata;
      end else begin
        check("sb_mgmt_rdata", mgmt_rdata, e.rdata);
        check("sb_hk_rdata_kept", hk_rdata, exp_hk_rd);
        exp_mgmt_rd = e.rdata;
      end
    end
  endtask

  // Starting from the enable-cycle sample, expects the owner's ack exp_k samples later.
  task automatic wait_ack(input bit hk, input int exp_k);
    int k  = 0;
    bit seen = 0;
    while (!seen && k < 10) begin
      wait_cycle();
      k++;
      if (hk ? hk_ack : mgmt_ack) seen = 1;
    end
    if (!seen) begin
      check("ack_timeout", 0, 1);
    end else begin
      check("ack_latency", 32'(k), 32'(exp_k));
      check("other_ack_low", 32'(hk ? mgmt_ack : hk_ack), 0);
      pop_compare();
    end
  endtask

  task automatic access(input bit hk, input bit we, input logic [SW-1:0] sel,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] exp_rd);
    sb_t e;
    @(negedge core_clk);
    if (hk) begin
      hk_req = 1'b1; hk_addr = addr;
    end else begin
      mgmt_req = 1'b1; mgmt_we = we; mgmt_sel = sel; mgmt_addr = addr; mgmt_wdata = wdata;
    end
    e.hk    = hk;
    e.rdata = (!hk && we) ? exp_mgmt_rd : exp_rd;
    sb_q.push_back(e);
    wait_cycle();
    check("ram_ena_n1", 32'(ram_ena), 1);
    check("ram_wen", 32'(ram_wen), 32'(!hk && we));
    check("ram_mask", 32'(ram_wen_mask), (!hk && we) ? 32'(sel) : 0);
    check("ram_addr", 32'(ram_addr), 32'(addr));
    if (!hk && we) check("ram_wdata", ram_wdata, wdata);
    check("busy_access", 32'(busy), 1);
    wait_ack(hk, 2);
    mgmt_req = 1'b0;
    hk_req   = 1'b0;
    wait_cycle();
    check("ack_one_cycle", 32'({mgmt_ack, hk_ack}), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  task automatic reset_dut();
    @(negedge core_clk);
    core_rstn = 1'b0;
    #1;
    exp_mgmt_rd = '0;
    exp_hk_rd   = '0;
    @(negedge core_clk);
    core_rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, last, n_acks, hk_acks;

    vecs[0]  = '{0, 1, 4'hF, 8'h10, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1, 0, 4'h0, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{0, 1, 4'hF, 8'h20, 32'h11223344, 32'h0};
    vecs[3]  = '{0, 1, 4'h4, 8'h20, 32'h00AB0000, 32'h0};
    vecs[4]  = '{0, 0, 4'h0, 8'h20, 32'h0,        32'h11AB3344};
    vecs[5]  = '{0, 1, 4'h0, 8'h20, 32'hFFFFFFFF, 32'h0};
    vecs[6]  = '{1, 0, 4'h0, 8'h20, 32'h0,        32'h11AB3344};
    vecs[7]  = '{0, 1, 4'hF, 8'hFF, 32'h0A0B0C0D, 32'h0};
    vecs[8]  = '{0, 0, 4'h0, 8'hFF, 32'h0,        32'h0A0B0C0D};
    vecs[9]  = '{1, 0, 4'h0, 8'hFF, 32'h0,        32'h0A0B0C0D};
    vecs[10] = '{0, 0, 4'h0, 8'h10, 32'h0,        32'hDEADBEEF};

    // Reset state
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge core_clk);
    core_rstn = 1'b1;

    for (int i = 0; i < 11; i++)
      access(vecs[i].hk, vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    // Inputs change and req drops after grant; hk arrives exactly in the ACK cycle.
    @(negedge core_clk);
    mgmt_req = 1'b1; mgmt_we = 1'b1; mgmt_sel = 4'hF; mgmt_addr = 8'h30; mgmt_wdata = 32'h00000055;
    sb_q.push_back('{0, exp_mgmt_rd});
    wait_cycle();
    check("latched_addr", 32'(ram_addr), 32'h30);
    check("latched_wdata", ram_wdata, 32'h55);
    mgmt_req = 1'b0; mgmt_addr = 8'h31; mgmt_wdata = 32'hFFFFFFFF; mgmt_we = 1'b0;
    wait_ack(0, 2);
    check("addr_held", 32'(ram_addr), 32'h30);
    hk_req = 1'b1; hk_addr = 8'h30;
    sb_q.push_back('{1, 32'h00000055});
    wait_cycle();
    check("ack_cycle_req_ignored", 32'(ram_ena), 0);
    wait_cycle();
    check("next_idle_grant", 32'(ram_ena), 1);
    check("next_idle_addr", 32'(ram_addr), 32'h30);
    wait_ack(1, 2);
    hk_req = 1'b0;
    wait_cycle();

    // Both requesting continuously from reset: mgmt first, strict alternation.
    reset_dut();
    @(negedge core_clk);
    mgmt_req = 1'b1; mgmt_we = 1'b0; mgmt_addr = 8'h10;
    hk_req   = 1'b1; hk_addr   = 8'h20;
    for (int i = 0; i < 8; i++)
      sb_q.push_back((i % 2 == 0) ? '{0, 32'hDEADBEEF} : '{1, 32'h11AB3344});
    k = 0; last = 0; n_acks = 0;
    while (n_acks < 8 && k < 60) begin
      wait_cycle();
      k++;
      if (mgmt_ack && hk_ack) check("dual_ack", 1, 0);
      if (mgmt_ack || hk_ack) begin
        check("grant_spacing", 32'(k - last), (n_acks == 0) ? 32'd3 : 32'd4);
        last = k;
        n_acks++;
        if (n_acks == 8) begin
          mgmt_req = 1'b0;
          hk_req   = 1'b0;
        end
        pop_compare();
      end
    end
    check("fair_acks_done", 32'(n_acks), 8);
    check("sb_empty", 32'(sb_q.size()), 0);
    wait_cycle();

    // Reset during WAIT of an hk read: no ack, outputs cleared, reissue works.
    @(negedge core_clk);
    hk_req = 1'b1; hk_addr = 8'hFF;
    wait_cycle();
    wait_cycle();
    check("busy_in_wait", 32'(busy), 1);
    core_rstn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_mgmt_rd = '0;
    exp_hk_rd   = '0;
    hk_req = 1'b0;
    @(negedge core_clk);
    core_rstn = 1'b1;
    hk_acks = 0;
    repeat (6) begin
      wait_cycle();
      if (hk_ack) hk_acks++;
    end
    check("no_ack_after_abort", 32'(hk_acks), 0);
    access(1, 0, 4'h0, 8'hFF, 32'h0, 32'h0A0B0C0D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
